// File: rtl/dram_load_unit.sv
// dram_load_unit
//   Sequential load unit between the LSU issue stage and the data-memory port.
//   It accepts one load at a time and issues word-aligned memory reads. A load
//   that crosses a word boundary is split into two beats. The returned bytes
//   are merged, shifted and sign/zero-extended into the response.
//
//   Optional feature macro: DRAM_LOAD_MISALIGN_EN
//     defined   : boundary-crossing loads are split into two memory beats
//     undefined : boundary-crossing loads return err=1 without touching memory
//
//   Ports
//     clk, rst_n                      clock, async active-low reset
//     ld_req_valid/ready/addr/type    load request (type one-hot
//                                     {lwu, ld, lhu, lbu, lw, lh, lb})
//     mem_req_valid/ready/addr        word-aligned memory read request
//     mem_rsp_valid/data              in-order read data, one per request
//     ld_rsp_valid/ready/data/err     extended load result
module dram_load_unit #(
  parameter int XLEN = 32,
  parameter int AW   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_req_valid,
  output logic            ld_req_ready,
  input  logic [AW-1:0]   ld_req_addr,
  input  logic [6:0]      ld_req_type,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            ld_rsp_valid,
  input  logic            ld_rsp_ready,
  output logic [XLEN-1:0] ld_rsp_data,
  output logic            ld_rsp_err
);

  localparam int WB   = XLEN / 8;
  localparam int OFFW = $clog2(WB);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } state_t;

  function automatic logic type_onehot(input logic [6:0] t);
    return (t != 7'd0) && ((t & (t - 7'd1)) == 7'd0);
  endfunction

  // Access size in bytes; zero for an encoding that is not a known type.
  function automatic logic [3:0] type_size(input logic [6:0] t);
    logic [3:0] s;
    if (t[0] || t[3]) begin
      s = 4'd1;
    end else if (t[1] || t[4]) begin
      s = 4'd2;
    end else if (t[2] || t[6]) begin
      s = 4'd4;
    end else if (t[5]) begin
      s = 4'd8;
    end else begin
      s = 4'd0;
    end
    return s;
  endfunction

  function automatic logic crosses(input logic [OFFW-1:0] off, input logic [3:0] size);
    logic [4:0] sum;
    sum = 5'(off) + 5'(size);
    return sum > 5'(WB);
  endfunction

  // Two-beat window shifted so the addressed byte lands at bit 0.
  function automatic logic [XLEN-1:0] merge_beats(input logic [XLEN-1:0] hi,
                                                  input logic [XLEN-1:0] lo,
                                                  input logic [OFFW-1:0] off);
    logic [2*XLEN-1:0] cat;
    cat = {hi, lo} >> {off, 3'b000};
    return cat[XLEN-1:0];
  endfunction

  // Left-justify the loaded field, then shift back arithmetically or logically.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw,
                                             input logic [6:0] t);
    logic signed [XLEN-1:0] tmp;
    int nbits;
    nbits = 8 * int'(type_size(t));
    tmp   = raw;
    if ((nbits > 0) && (nbits < XLEN)) begin
      tmp = tmp << (XLEN - nbits);
      if (t[0] || t[1] || t[2]) begin
        tmp = tmp >>> (XLEN - nbits);
      end else begin
        tmp = tmp >> (XLEN - nbits);
      end
    end else begin
      tmp = raw;
    end
    return tmp;
  endfunction

  state_t            state_r, state_n;
  logic              ld_req_ready_r, mem_req_valid_r, ld_rsp_valid_r;
  logic [AW-1:0]     mem_req_addr_r, addr_n;
  logic [XLEN-1:0]   ld_rsp_data_r, rsp_data_n;
  logic              ld_rsp_err_r, rsp_err_n;
  logic [OFFW-1:0]   off_r;
  logic [6:0]        type_r;
  logic              cap_req_s, load_rsp_s, load_addr_s;
  logic [3:0]        req_size_s;
  logic              req_illegal_s, req_bad_s;
`ifdef DRAM_LOAD_MISALIGN_EN
  logic              cross_r;
  logic [XLEN-1:0]   beat0_r;
  logic              load_beat0_s;
`endif

  assign req_size_s    = type_size(ld_req_type);
  assign req_illegal_s = !type_onehot(ld_req_type) ||
                         ((ld_req_type[5] || ld_req_type[6]) && (XLEN == 32));
`ifdef DRAM_LOAD_MISALIGN_EN
  assign req_bad_s     = req_illegal_s;
`else
  // Without splitting, a crossing load is rejected before any memory access.
  assign req_bad_s     = req_illegal_s || crosses(ld_req_addr[OFFW-1:0], req_size_s);
`endif

  assign ld_req_ready  = ld_req_ready_r;
  assign mem_req_valid = mem_req_valid_r;
  assign mem_req_addr  = mem_req_addr_r;
  assign ld_rsp_valid  = ld_rsp_valid_r;
  assign ld_rsp_data   = ld_rsp_data_r;
  assign ld_rsp_err    = ld_rsp_err_r;

  // Next-state and datapath load strobes.
  always_comb begin
    state_n      = state_r;
    cap_req_s    = 1'b0;
    load_rsp_s   = 1'b0;
    rsp_data_n   = {XLEN{1'b0}};
    rsp_err_n    = 1'b0;
    load_addr_s  = 1'b0;
    addr_n       = mem_req_addr_r;
`ifdef DRAM_LOAD_MISALIGN_EN
    load_beat0_s = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (ld_req_valid) begin
          cap_req_s = 1'b1;
          if (req_bad_s) begin
            state_n    = RESP;
            load_rsp_s = 1'b1;
            rsp_err_n  = 1'b1;
          end else begin
            state_n     = REQ0;
            load_addr_s = 1'b1;
            addr_n      = {ld_req_addr[AW-1:OFFW], {OFFW{1'b0}}};
          end
        end else begin
          state_n = IDLE;
        end
      end
      REQ0: begin
        if (mem_req_ready) begin
          state_n = WAIT0;
        end else begin
          state_n = REQ0;
        end
      end
      WAIT0: begin
        if (mem_rsp_valid) begin
          state_n    = RESP;
          load_rsp_s = 1'b1;
          rsp_data_n = extend(merge_beats({XLEN{1'b0}}, mem_rsp_data, off_r), type_r);
`ifdef DRAM_LOAD_MISALIGN_EN
          if (cross_r) begin
            state_n      = REQ1;
            load_rsp_s   = 1'b0;
            load_beat0_s = 1'b1;
            load_addr_s  = 1'b1;
            addr_n       = mem_req_addr_r + AW'(WB);
          end else begin
            state_n = RESP;
          end
`endif
        end else begin
          state_n = WAIT0;
        end
      end
`ifdef DRAM_LOAD_MISALIGN_EN
      REQ1: begin
        if (mem_req_ready) begin
          state_n = WAIT1;
        end else begin
          state_n = REQ1;
        end
      end
      WAIT1: begin
        if (mem_rsp_valid) begin
          state_n    = RESP;
          load_rsp_s = 1'b1;
          rsp_data_n = extend(merge_beats(mem_rsp_data, beat0_r, off_r), type_r);
        end else begin
          state_n = WAIT1;
        end
      end
`endif
      RESP: begin
        if (ld_rsp_ready) begin
          state_n = IDLE;
        end else begin
          state_n = RESP;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register; handshake flags are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      ld_req_ready_r  <= 1'b1;
      mem_req_valid_r <= 1'b0;
      ld_rsp_valid_r  <= 1'b0;
    end else begin
      state_r         <= state_n;
      ld_req_ready_r  <= (state_n == IDLE);
      mem_req_valid_r <= (state_n == REQ0) || (state_n == REQ1);
      ld_rsp_valid_r  <= (state_n == RESP);
    end
  end

  // Request fields, memory address, first beat and response payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_r          <= {OFFW{1'b0}};
      type_r         <= 7'd0;
      mem_req_addr_r <= {AW{1'b0}};
      ld_rsp_data_r  <= {XLEN{1'b0}};
      ld_rsp_err_r   <= 1'b0;
`ifdef DRAM_LOAD_MISALIGN_EN
      cross_r        <= 1'b0;
      beat0_r        <= {XLEN{1'b0}};
`endif
    end else begin
      if (cap_req_s) begin
        off_r  <= ld_req_addr[OFFW-1:0];
        type_r <= ld_req_type;
`ifdef DRAM_LOAD_MISALIGN_EN
        cross_r <= crosses(ld_req_addr[OFFW-1:0], req_size_s);
`endif
      end
      if (load_addr_s) begin
        mem_req_addr_r <= addr_n;
      end
      if (load_rsp_s) begin
        ld_rsp_data_r <= rsp_data_n;
        ld_rsp_err_r  <= rsp_err_n;
      end
`ifdef DRAM_LOAD_MISALIGN_EN
      if (load_beat0_s) begin
        beat0_r <= mem_rsp_data;
      end
`endif
    end
  end

endmodule
